// File: rtl/morse_round_ctrl.sv
`default_nettype none
// =============================================================================
// morse_round_ctrl : two-player Morse record/replay round controller.
// Optional macro MORSE_HINT_EN shows the expected stored symbol in P2TURN.
// Revision : 1.0
// =============================================================================
module morse_round_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SYM_W  = 10
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              tick_i,
  input  logic              key_press_i,
  input  logic              next_pulse_i,
  input  logic              done_pulse_i,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   p1_addr_o,
  output logic [ADDR_W:0]   p2_addr_o,
  output logic [SYM_W-1:0]  live_sym_o,
  output logic [SYM_W-1:0]  led_value_o,
  output logic [ADDR_W:0]   mismatch_cnt_o,
  output logic              full_o,
  output logic              pass_o
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_P1     = 2'd1,
    ST_P2     = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]  c_depth_cnt = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]  c_one_cnt   = (ADDR_W+1)'(1);
  localparam logic [SYM_W-1:0] c_led_pass  = SYM_W'(1);

  state_t                 state_q, state_d;
  logic [ADDR_W:0]        p1_addr_q, p1_addr_d;
  logic [ADDR_W:0]        p2_addr_q, p2_addr_d;
  logic [ADDR_W:0]        mismatch_q, mismatch_d;
  logic [SYM_W-1:0]       live_sym_q, live_sym_d;
  logic [SYM_W-1:0]       cmp_sym_q, cmp_sym_d;
  logic                   cmp_busy_q, cmp_busy_d;
  logic                   pass_q, pass_d;
  logic [SYM_W-1:0]       rd_data_q;
  logic [SYM_W-1:0]       mem_q [DEPTH];

  logic                   w_full;
  logic                   w_mem_we;
  logic [ADDR_W-1:0]      w_waddr;
  logic [ADDR_W-1:0]      w_raddr;
  logic [SYM_W-1:0]       w_led;

  assign w_full  = (p1_addr_q == c_depth_cnt);
  assign w_waddr = p1_addr_q[ADDR_W-1:0];
  // Reading from the next address keeps rd_data_q aligned with p2_addr_q.
  assign w_raddr = p2_addr_d[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    p1_addr_d  = p1_addr_q;
    p2_addr_d  = p2_addr_q;
    mismatch_d = mismatch_q;
    cmp_sym_d  = cmp_sym_q;
    cmp_busy_d = cmp_busy_q;
    pass_d     = 1'b0;
    live_sym_d = live_sym_q;
    w_mem_we   = 1'b0;

    case (state_q)
      ST_START: begin
        if (done_pulse_i) begin
          state_d    = ST_P1;
          p1_addr_d  = '0;
          p2_addr_d  = '0;
          mismatch_d = '0;
        end
      end
      ST_P1: begin
        if (next_pulse_i && !w_full) begin
          w_mem_we  = 1'b1;
          p1_addr_d = p1_addr_q + c_one_cnt;
        end
        if (done_pulse_i) state_d = ST_P2;
      end
      ST_P2: begin
        if (cmp_busy_q) begin
          if ((cmp_sym_q != rd_data_q) && (mismatch_q != c_depth_cnt))
            mismatch_d = mismatch_q + c_one_cnt;
          p2_addr_d  = p2_addr_q + c_one_cnt;
          cmp_busy_d = 1'b0;
        end else if (next_pulse_i && !done_pulse_i && (p2_addr_q != p1_addr_q)) begin
          cmp_busy_d = 1'b1;
          cmp_sym_d  = live_sym_q;
        end
        if (done_pulse_i || (!cmp_busy_q && (p2_addr_q == p1_addr_q)))
          state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (done_pulse_i) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase

    // Verdict is latched on entry using the post-compare counters.
    if (state_d == ST_RESULT) begin
      if (state_q == ST_RESULT)
        pass_d = pass_q;
      else
        pass_d = (mismatch_d == '0) && (p2_addr_d == p1_addr_d) && (p1_addr_d != '0);
    end

    if ((state_d != state_q) || (state_q == ST_START) || (state_q == ST_RESULT) || next_pulse_i)
      live_sym_d = '0;
    else if (tick_i)
      live_sym_d = {live_sym_q[SYM_W-2:0], key_press_i};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_START;
      p1_addr_q  <= '0;
      p2_addr_q  <= '0;
      mismatch_q <= '0;
      live_sym_q <= '0;
      cmp_sym_q  <= '0;
      cmp_busy_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_addr_q  <= p1_addr_d;
      p2_addr_q  <= p2_addr_d;
      mismatch_q <= mismatch_d;
      live_sym_q <= live_sym_d;
      cmp_sym_q  <= cmp_sym_d;
      cmp_busy_q <= cmp_busy_d;
      pass_q     <= pass_d;
    end
  end

  // Symbol RAM, write-first so a same-edge write is visible on the read port.
  always_ff @(posedge clock_i) begin
    if (w_mem_we) mem_q[w_waddr] <= live_sym_q;
    rd_data_q <= (w_mem_we && (w_waddr == w_raddr)) ? live_sym_q : mem_q[w_raddr];
  end

  always_comb begin
    w_led = '1;
    case (state_q)
      ST_P1: w_led = live_sym_q;
      ST_P2: begin
`ifdef MORSE_HINT_EN
        w_led = (p2_addr_q == p1_addr_q) ? '0 : rd_data_q;
`else
        w_led = live_sym_q;
`endif
      end
      ST_RESULT: begin
        if (pass_q) w_led = c_led_pass;
      end
      default: w_led = '1;
    endcase
  end

  assign state_o        = state_q;
  assign p1_addr_o      = p1_addr_q;
  assign p2_addr_o      = p2_addr_q;
  assign live_sym_o     = live_sym_q;
  assign led_value_o    = w_led;
  assign mismatch_cnt_o = mismatch_q;
  assign full_o         = w_full;
  assign pass_o         = pass_q;

endmodule
`default_nettype wire
